// File: rtl/grf_pkg.sv
// Shared constants for the general-purpose register file and pending-write scoreboard.
// Holds default parameter values, the hard-wired zero register index and the counter
// saturation value.
package grf_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 5;
  localparam int unsigned DefNumRd = 2;
  localparam int unsigned DefCntW  = 2;

  // Register 0 always reads zero and never tracks pending writes.
  localparam int unsigned ZeroReg = 0;

  // All-ones value of a pending counter: the most writes that can be in flight.
  function automatic int unsigned cnt_max(int unsigned w);
    return (1 << w) - 1;
  endfunction

  localparam int unsigned DefCntMax = (1 << DefCntW) - 1;

endpackage

// File: rtl/grf_scoreboard_if.sv
// Bus between the decode/writeback stages and the register file scoreboard.
//   master: drives read addresses, writeback, issue and flush; receives read data,
//           busy flags and issue ready.
//   slave : the register file itself.
interface grf_scoreboard_if #(
  parameter int unsigned DATA_W = grf_pkg::DefDataW,
  parameter int unsigned ADDR_W = grf_pkg::DefAddrW,
  parameter int unsigned NUM_RD = grf_pkg::DefNumRd
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [31:0]              wr_pc;
  logic                     iss_valid;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     iss_ready;
  logic                     flush;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_pc, iss_valid, iss_addr, flush,
    input  rd_data, rd_busy, iss_ready
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_pc, iss_valid, iss_addr, flush,
    output rd_data, rd_busy, iss_ready
  );

endinterface

// File: rtl/grf_pend_ctr.sv
// Saturating up/down counter of in-flight writes to one register.
// Ports:
//   clk   - clock
//   reset - asynchronous active-low reset
//   inc   - accepted issue to this register
//   dec   - writeback to this register; ignored when the count is already zero
//   clr   - synchronous clear, overrides inc/dec
//   count - current pending count
//   busy  - count is non-zero
//   full  - count is saturated (all ones)
module grf_pend_ctr import grf_pkg::*; #(
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             full
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(cnt_max(CNT_W));

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dec_eff, inc_eff;

  always_comb begin
    dec_eff = dec && (cnt_q != '0);
    // An issue against a full counter only lands when a writeback frees a slot.
    inc_eff = inc && ((cnt_q != CntMax) || dec_eff);
    cnt_d   = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc_eff && !dec_eff) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec_eff && !inc_eff) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign busy  = (cnt_q != '0);
  assign full  = (cnt_q == CntMax);

endmodule

// File: rtl/grf_scoreboard.sv
// Register file with NUM_RD combinational read ports, one write port with write-to-read
// bypass, and a per-register pending-write counter used by decode for RAW hazard checks.
// Ports:
//   clk   - clock
//   reset - asynchronous active-low reset; while low all reads, busy flags and
//           iss_ready are forced to 0
//   bus   - grf_scoreboard_if slave: read ports, writeback, issue, flush
// Optional feature: define GRF_TRACE_EN to print a writeback trace line per write.
module grf_scoreboard import grf_pkg::*; #(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned NUM_RD = DefNumRd,
  parameter int unsigned CNT_W  = DefCntW
) (
  input logic             clk,
  input logic             reset,
  grf_scoreboard_if.slave bus
);

  localparam int unsigned       Depth = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] Zero  = ADDR_W'(ZeroReg);

  logic [DATA_W-1:0]             regs_q [Depth];
  logic [Depth-1:0][CNT_W-1:0]   cnt_v;
  logic [Depth-1:0]              busy_v;
  logic [Depth-1:0]              full_v;
  logic                          iss_wr_hit;
  logic                          iss_acc;

  // Register array; register 0 is never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else if (bus.wr_en && (bus.wr_addr != Zero)) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Issue is refused only when the counter is saturated and no writeback frees a slot.
  assign iss_wr_hit    = bus.wr_en && (bus.wr_addr == bus.iss_addr);
  assign bus.iss_ready = reset && ((bus.iss_addr == Zero) || !full_v[bus.iss_addr] ||
                                   iss_wr_hit);
  assign iss_acc       = bus.iss_valid && bus.iss_ready;

  assign cnt_v[0]  = '0;
  assign busy_v[0] = 1'b0;
  assign full_v[0] = 1'b0;

  for (genvar i = 1; i < Depth; i++) begin : g_ctr
    grf_pend_ctr #(
      .CNT_W (CNT_W)
    ) u_ctr (
      .clk   (clk),
      .reset (reset),
      .inc   (iss_acc && (bus.iss_addr == ADDR_W'(i))),
      .dec   (bus.wr_en && (bus.wr_addr == ADDR_W'(i))),
      .clr   (bus.flush),
      .count (cnt_v[i]),
      .busy  (busy_v[i]),
      .full  (full_v[i])
    );
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit;

    assign addr = bus.rd_addr[k*ADDR_W +: ADDR_W];
    assign hit  = bus.wr_en && (bus.wr_addr == addr);

    assign bus.rd_data[k*DATA_W +: DATA_W] = (!reset || (addr == Zero)) ? '0 :
                                             hit ? bus.wr_data : regs_q[addr];
    // A writeback retiring the last pending write clears busy in the same cycle.
    assign bus.rd_busy[k] = reset && busy_v[addr] && !(hit && (cnt_v[addr] == CNT_W'(1)));
  end

`ifdef GRF_TRACE_EN
  // Includes writes to register 0 so the log matches the reference trace.
  always_ff @(posedge clk) begin
    if (reset && bus.wr_en) begin
      $display("@%h: $%d <= %h", bus.wr_pc, bus.wr_addr, bus.wr_data);
    end
  end
`else
  logic unused_wr_pc;
  assign unused_wr_pc = ^bus.wr_pc;
`endif

endmodule
